// File: rtl/vc4000_cart_loader.sv
// Cartridge RAM owner: arbitrates HPS downloads and CPU fetches, fills the
// unused tail after a load, derives the mirror mask and holds the CPU meanwhile.
module vc4000_cart_loader #(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned LOAD_INDEX = 1,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF,
  parameter int unsigned HOLD_CYC   = 16,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic              cpu_req,
  input  logic [14:0]       cpu_addr,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout,
  output logic [ADDR_W:0]   cart_size,
  output logic [ADDR_W-1:0] cart_mask
);

  localparam int unsigned SIZE_W = ADDR_W + 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned HCNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int unsigned RCNT_W = 2;
  localparam logic [SIZE_W-1:0] FULL = SIZE_W'(DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_FILL, ST_HOLD} state_t;

  state_t              state_q, state_d;
  logic                dl_q, dl_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                ioctl_wait_q, ioctl_wait_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]          ram_din_q, ram_din_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic [7:0]          cpu_rdata_q, cpu_rdata_d;
  logic [SIZE_W-1:0]   cart_size_q, cart_size_d;
  logic [ADDR_W-1:0]   cart_mask_q, cart_mask_d;
  logic [SIZE_W-1:0]   fill_ptr_q, fill_ptr_d;
  logic [HCNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                rd_busy_q, rd_busy_d;
  logic [RCNT_W-1:0]   rd_cnt_q, rd_cnt_d;

  logic                load_hit_c;
  logic                dl_rise_c;
  logic [25:0]         addr_p1_c;
  logic                in_range_c;
  logic [SIZE_W-1:0]   byte_lim_c;
  logic [ADDR_W-1:0]   size_m1_c;
  logic [ADDR_W-1:0]   mask_c;
  logic                mask_acc_c;
  logic                unused_c;

  assign unused_c   = ^{ioctl_index[7:6], cpu_addr[14:ADDR_W]};
  assign load_hit_c = ioctl_download && (ioctl_index[5:0] == 6'(LOAD_INDEX));
  assign dl_rise_c  = load_hit_c && !dl_q;
  assign addr_p1_c  = 26'(ioctl_addr) + 26'd1;
  assign in_range_c = (addr_p1_c <= 26'(DEPTH));
  assign byte_lim_c = in_range_c ? SIZE_W'(addr_p1_c) : FULL;

  // Mirror mask: smear the highest set bit of (size-1) downwards.
  always_comb begin
    size_m1_c  = ADDR_W'(cart_size_q - SIZE_W'(1));
    mask_acc_c = 1'b0;
    mask_c     = '0;
    for (int i = int'(ADDR_W) - 1; i >= 0; i--) begin
      mask_acc_c = mask_acc_c | size_m1_c[i];
      mask_c[i]  = mask_acc_c;
    end
    if (cart_size_q == '0) mask_c = '0;
  end

  always_comb begin
    state_d      = state_q;
    dl_d         = ioctl_download;
    cpu_hold_d   = cpu_hold_q;
    ioctl_wait_d = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    cpu_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    cart_size_d  = cart_size_q;
    cart_mask_d  = cart_mask_q;
    fill_ptr_d   = fill_ptr_q;
    hold_cnt_d   = hold_cnt_q;
    rd_busy_d    = rd_busy_q;
    rd_cnt_d     = rd_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (load_hit_c) begin
          state_d     = ST_LOAD;
          cpu_hold_d  = 1'b1;
          rd_busy_d   = 1'b0;
          cart_size_d = '0;
        end else if (rd_busy_q) begin
          if (rd_cnt_q == '0) begin
            cpu_ack_d   = 1'b1;
            cpu_rdata_d = ram_dout;
            rd_busy_d   = 1'b0;
          end else begin
            rd_cnt_d = rd_cnt_q - RCNT_W'(1);
          end
        end else if (cpu_req) begin
          ram_addr_d = cpu_addr[ADDR_W-1:0] & cart_mask_q;
          rd_busy_d  = 1'b1;
          rd_cnt_d   = RCNT_W'(RD_LAT);
        end
      end

      ST_LOAD: begin
        if (ioctl_wr && !ioctl_wait_q) begin
          ioctl_wait_d = 1'b1;
          if (in_range_c) begin
            ram_we_d   = 1'b1;
            ram_addr_d = ioctl_addr[ADDR_W-1:0];
            ram_din_d  = ioctl_dout;
          end
          if (byte_lim_c > cart_size_q) cart_size_d = byte_lim_c;
        end
        // A write accepted in the same cycle still lands before the fill starts.
        if (!ioctl_download) begin
          state_d    = ST_FILL;
          fill_ptr_d = cart_size_d;
        end
      end

      ST_FILL: begin
        if (dl_rise_c) begin
          state_d     = ST_LOAD;
          cart_size_d = '0;
        end else begin
          cart_mask_d = mask_c;
          if (fill_ptr_q == FULL) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
          end else begin
            ram_we_d   = 1'b1;
            ram_addr_d = fill_ptr_q[ADDR_W-1:0];
            ram_din_d  = FILL_BYTE;
            fill_ptr_d = fill_ptr_q + SIZE_W'(1);
          end
        end
      end

      ST_HOLD: begin
        if (dl_rise_c) begin
          state_d     = ST_LOAD;
          cart_size_d = '0;
        end else if (hold_cnt_q == HCNT_W'(HOLD_CYC - 1)) begin
          state_d    = ST_RUN;
          cpu_hold_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + HCNT_W'(1);
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      dl_q         <= 1'b0;
      cpu_hold_q   <= 1'b0;
      ioctl_wait_q <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      cart_size_q  <= '0;
      cart_mask_q  <= '0;
      fill_ptr_q   <= '0;
      hold_cnt_q   <= '0;
      rd_busy_q    <= 1'b0;
      rd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      dl_q         <= dl_d;
      cpu_hold_q   <= cpu_hold_d;
      ioctl_wait_q <= ioctl_wait_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cart_size_q  <= cart_size_d;
      cart_mask_q  <= cart_mask_d;
      fill_ptr_q   <= fill_ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      rd_busy_q    <= rd_busy_d;
      rd_cnt_q     <= rd_cnt_d;
    end
  end

  assign ioctl_wait = ioctl_wait_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign ram_we     = ram_we_q;
  assign cart_size  = cart_size_q;
  assign cart_mask  = cart_mask_q;

endmodule

// File: tb/tb_vc4000_cart_loader.sv
// Scoreboard bench for vc4000_cart_loader: expected RAM writes and CPU acks are
// queued at stimulus time and popped by a negedge monitor.
module tb_vc4000_cart_loader;

  localparam int unsigned ADDR_W   = 13;
  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned HOLD_CYC = 16;
  localparam int unsigned RD_LAT   = 1;

  logic              clk;
  logic              reset_n;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic              cpu_req;
  logic [14:0]       cpu_addr;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;
  logic              cpu_hold;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic [7:0]        ram_dout;
  logic [ADDR_W:0]   cart_size;
  logic [ADDR_W-1:0] cart_mask;

  vc4000_cart_loader #(
    .ADDR_W(ADDR_W), .LOAD_INDEX(1), .FILL_BYTE(8'hFF),
    .HOLD_CYC(HOLD_CYC), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .cart_size(cart_size), .cart_mask(cart_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous cart RAM with RD_LAT cycles of read latency.
  logic [7:0] ram [DEPTH];
  logic [7:0] rd_p0, rd_p1;
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    rd_p0 <= ram[ram_addr];
    rd_p1 <= rd_p0;
  end
  assign ram_dout = (RD_LAT == 1) ? rd_p0 : rd_p1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [ADDR_W-1:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [7:0] d; int due; } rd_t;
  wr_t exp_wr[$];
  rd_t exp_rd[$];

  logic [7:0] ref_mem [DEPTH];
  int ref_mask = 0;
  int last_we_cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  wr_t w_pop;
  rd_t r_pop;
  always @(negedge clk) begin
    if (reset_n) begin
      if (ram_we) begin
        last_we_cyc = cyc;
        chk("write_expected", longint'(exp_wr.size() > 0), 1);
        chk("write_under_hold", cpu_hold, 1);
        if (exp_wr.size() > 0) begin
          w_pop = exp_wr.pop_front();
          chk("wr_addr", ram_addr, w_pop.a);
          chk("wr_data", ram_din, w_pop.d);
        end
      end
      if (cpu_ack) begin
        chk("ack_expected", longint'(exp_rd.size() > 0), 1);
        if (exp_rd.size() > 0) begin
          r_pop = exp_rd.pop_front();
          chk("ack_data", cpu_rdata, r_pop.d);
          chk("ack_cycle", cyc, r_pop.due);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_hold"},   cpu_hold,   0);
    chk({tag, "_ioctl_wait"}, ioctl_wait, 0);
    chk({tag, "_ram_we"},     ram_we,     0);
    chk({tag, "_cpu_ack"},    cpu_ack,    0);
    chk({tag, "_cpu_rdata"},  cpu_rdata,  0);
    chk({tag, "_ram_addr"},   ram_addr,   0);
    chk({tag, "_ram_din"},    ram_din,    0);
    chk({tag, "_cart_size"},  cart_size,  0);
    chk({tag, "_cart_mask"},  cart_mask,  0);
  endtask

  task automatic cpu_read(input logic [14:0] a);
    rd_t r;
    int  idx;
    idx      = int'(a[ADDR_W-1:0]) & ref_mask;
    cpu_req  = 1'b1;
    cpu_addr = a;
    step();
    cpu_req  = 1'b0;
    r.d      = ref_mem[idx];
    r.due    = cyc + int'(RD_LAT) + 1;
    exp_rd.push_back(r);
    chk("rd_ram_addr", ram_addr, idx);
    repeat (RD_LAT + 3) step();
    chk("ack_outstanding", exp_rd.size(), 0);
  endtask

  task automatic random_reads(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) step();
      cpu_read(15'($urandom));
    end
  endtask

  // Full load of n bytes; abort_at >= 0 pulls reset_n low before that byte.
  task automatic load(input int n, input bit rnd, input int abort_at);
    int  esize, emask, p, drop, fall, d, bound;
    wr_t w;
    logic [7:0] b;
    ioctl_download = 1'b1;
    ioctl_index    = 8'd1;
    step();
    chk("hold_on_load_start", cpu_hold, 1);
    for (int a = 0; a < n; a++) begin
      if (a == abort_at) begin
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        exp_wr.delete();
        exp_rd.delete();
        ioctl_download = 1'b0;
        step();
        step();
        #2 reset_n = 1'b1;
        ref_mask = 0;
        step();
        chk("post_reset_size", cart_size, 0);
        return;
      end
      b          = rnd ? 8'($urandom) : 8'(a);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = b;
      if (a < int'(DEPTH)) begin
        w.a = ADDR_W'(a);
        w.d = b;
        exp_wr.push_back(w);
        ref_mem[a] = b;
      end
      step();
      ioctl_wr = 1'b0;
      chk("wait_high", ioctl_wait, 1);
      step();
      chk("wait_low", ioctl_wait, 0);
    end
    esize = (n < int'(DEPTH)) ? n : int'(DEPTH);
    p = 1;
    while (p < esize) p = p * 2;
    emask = (esize == 0) ? 0 : p - 1;
    for (int a = esize; a < int'(DEPTH); a++) begin
      w.a = ADDR_W'(a);
      w.d = 8'hFF;
      exp_wr.push_back(w);
      ref_mem[a] = 8'hFF;
    end
    ioctl_download = 1'b0;
    step();
    drop = cyc;
    chk("size_at_drop", cart_size, esize);
    bound = 0;
    while (cpu_hold && bound < int'(DEPTH + HOLD_CYC) + 50) begin
      step();
      bound++;
    end
    chk("hold_released", cpu_hold, 0);
    fall = cyc;
    d = fall - ((last_we_cyc > drop) ? last_we_cyc : drop);
    chk("hold_length_ok", longint'(d >= int'(HOLD_CYC) && d <= int'(HOLD_CYC) + 3), 1);
    chk("fill_complete", exp_wr.size(), 0);
    chk("cart_size", cart_size, esize);
    chk("cart_mask", cart_mask, emask);
    ref_mask = emask;
  endtask

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    cpu_req        = 1'b0;
    cpu_addr       = '0;
    repeat (3) step();
    check_reset_outputs("reset");
    #2 reset_n = 1'b1;
    step();

    // 2 KiB image, data = low address byte, then mirrored CPU reads
    load(2048, 1'b0, -1);
    chk("mask_2k", cart_mask, 13'h07FF);
    cpu_read(15'h0805);
    random_reads(20);

    // second request while a read is outstanding is dropped
    begin
      rd_t r;
      cpu_req  = 1'b1;
      cpu_addr = 15'h0123;
      step();
      r.d   = ref_mem[int'(13'h0123) & ref_mask];
      r.due = cyc + int'(RD_LAT) + 1;
      exp_rd.push_back(r);
      cpu_addr = 15'h0456;
      step();
      cpu_req = 1'b0;
      chk("busy_addr_held", ram_addr, 13'h0123);
      repeat (RD_LAT + 4) step();
      chk("busy_single_ack", exp_rd.size(), 0);
    end

    // foreign download index: no hold, no writes, reads keep working
    ioctl_download = 1'b1;
    ioctl_index    = 8'd2;
    step();
    chk("idx2_no_hold", cpu_hold, 0);
    for (int i = 0; i < 4; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'($urandom);
      step();
      ioctl_wr = 1'b0;
      chk("idx2_no_wait", ioctl_wait, 0);
      step();
    end
    random_reads(5);
    chk("idx2_still_no_hold", cpu_hold, 0);
    ioctl_download = 1'b0;
    step();

    load(3000, 1'b1, -1);
    chk("mask_3000", cart_mask, 13'h0FFF);
    random_reads(10);

    load(10000, 1'b1, -1);
    chk("size_sat", cart_size, 14'd8192);
    chk("mask_full", cart_mask, 13'h1FFF);
    random_reads(10);

    // read issued one cycle before a download must never be acknowledged
    cpu_req  = 1'b1;
    cpu_addr = 15'($urandom);
    step();
    cpu_req = 1'b0;
    load(2048, 1'b1, -1);
    random_reads(10);

    // asynchronous reset in the middle of a load
    load(2048, 1'b1, 500);
    random_reads(5);

    repeat (5) step();
    chk("final_wr_queue", exp_wr.size(), 0);
    chk("final_rd_queue", exp_rd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
